// File: rtl/perif_pkg.sv
// Shared definitions for the PERIF-region UART transmitter.
//
// Contents:
//   - register offsets selected by address[4:3]
//   - STATUS and CTRL bit positions
//   - transmit FSM state encoding (IDLE must stay 0)
//   - baud divisor width and a helper that maps a divisor of 0 to 1
package perif_pkg;

  // Register offsets as seen on address[4:3]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  // STATUS bit positions
  localparam int STAT_BUSY     = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_EMPTY    = 2;
  localparam int STAT_COUNT_LO = 3;
  localparam int STAT_COUNT_W  = 3;
  localparam int STAT_OVF      = 6;

  // CTRL bit positions
  localparam int CTRL_TXEN  = 0;
  localparam int CTRL_IRQEN = 1;

  // Width of the baud divisor register and baud counter
  localparam int DIV_W = 16;

  // Transmit FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } txState_e;

  // A programmed divisor of zero would give a zero-length bit, so it is
  // treated as one clock per bit.
  function automatic logic [DIV_W-1:0] effDiv(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous first-word-fall-through FIFO.
//
// Ports:
//   clock_i     system clock
//   reset_i     synchronous active-high reset, empties the FIFO
//   push_i      write pushData_i this edge (dropped when full and no pop)
//   pushData_i  data to store
//   pop_i       discard the head entry this edge (ignored when empty)
//   popData_o   current head entry, valid while empty_o is low
//   full_o      count_o == DEPTH
//   empty_o     count_o == 0
//   count_o     number of stored entries
//
// A push and a pop on the same edge are both honoured, including when
// the FIFO is full: the head is consumed while the new entry takes the
// freed slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         popData_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign popData_o = mem_q[rdPtr_q];

  // Work out which requests actually take effect this edge and the
  // resulting pointer/count values. Pointers wrap naturally because
  // DEPTH is a power of two.
  always_comb begin
    doPop   = pop_i && !empty_o;
    doPush  = push_i && (!full_o || doPop);
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clock_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/perif_uart_tx.sv
// Memory-mapped UART transmitter (8N1, LSB first) in the PERIF region.
//
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   cs           peripheral select
//   address      byte address, bits [4:3] pick the register
//   write_en     1 = store, 0 = load (qualified by cs)
//   size         access size, not used by this block
//   data_in      store data
//   data_out     load data, zero when not reading
//   data_out_en  high while cs && !write_en
//   tx           serial output, idles high
//   tx_irq       registered interrupt: irq_en && FIFO empty && FSM idle
//
// Registers (address[4:3]):
//   0 TXDATA  (W)   push data_in[7:0], reads 0
//   1 STATUS  (R/W) {ovf, count[2:0], empty, full, busy}; write 1 to bit6 clears ovf
//   2 BAUDDIV (R/W) clock cycles per bit, 0 behaves as 1
//   3 CTRL    (R/W) {irq_en, tx_enable}
module perif_uart_tx
  import perif_pkg::*;
#(
  parameter int               FIFO_DEPTH = 4,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd4,
  parameter int               DATA_W     = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs,
  input  logic [31:0]       address,
  input  logic              write_en,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_en,
  output logic              tx,
  output logic              tx_irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic [1:0] regSel;
  logic       wrStrobe;
  logic       rdStrobe;
  logic       pushReq;

  // FIFO interface
  logic             popReq;
  logic [7:0]       fifoHead;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CNT_W-1:0] fifoCount;

  // Register file
  logic [DIV_W-1:0] baudDiv_q, baudDiv_d;
  logic             txEn_q, txEn_d;
  logic             irqEn_q, irqEn_d;
  logic             overflow_q, overflow_d;

  // Transmit engine
  txState_e         state_q, state_d;
  logic [DIV_W-1:0] baudCnt_q, baudCnt_d;
  logic [DIV_W-1:0] bitDiv_q, bitDiv_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             irq_q, irq_d;
  logic             bitEnd;
  logic             busy;

  // Read data before the output enable gate
  logic [DATA_W-1:0] rdData;

  // Address bits outside [4:3], the access size and the upper store data
  // have no meaning for this block.
  logic unusedBits;
  assign unusedBits = ^{address[31:5], address[2:0], size, data_in[DATA_W-1:DIV_W]};

  assign regSel      = address[4:3];
  assign wrStrobe    = cs && write_en;
  assign rdStrobe    = cs && !write_en;
  assign pushReq     = wrStrobe && (regSel == REG_TXDATA);
  assign data_out_en = rdStrobe;
  assign busy        = (state_q != ST_IDLE);
  assign tx          = tx_q;
  assign tx_irq      = irq_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clock_i    (clock),
    .reset_i    (reset),
    .push_i     (pushReq),
    .pushData_i (data_in[7:0]),
    .pop_i      (popReq),
    .popData_o  (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  // Register writes. Overflow is raised only when a push is actually
  // refused, i.e. the FIFO is full and the transmitter is not popping on
  // the same edge. A clear and a refused push cannot collide because they
  // target different registers.
  always_comb begin
    baudDiv_d  = baudDiv_q;
    txEn_d     = txEn_q;
    irqEn_d    = irqEn_q;
    overflow_d = overflow_q;
    if (wrStrobe) begin
      case (regSel)
        REG_STATUS: begin
          if (data_in[STAT_OVF]) begin
            overflow_d = 1'b0;
          end
        end
        REG_BAUDDIV: baudDiv_d = data_in[DIV_W-1:0];
        REG_CTRL: begin
          txEn_d  = data_in[CTRL_TXEN];
          irqEn_d = data_in[CTRL_IRQEN];
        end
        default: ;
      endcase
    end
    if (pushReq && fifoFull && !popReq) begin
      overflow_d = 1'b1;
    end
  end

  // Register file state
  always_ff @(posedge clock) begin
    if (reset) begin
      baudDiv_q  <= DIV_RESET;
      txEn_q     <= 1'b1;
      irqEn_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      baudDiv_q  <= baudDiv_d;
      txEn_q     <= txEn_d;
      irqEn_q    <= irqEn_d;
      overflow_q <= overflow_d;
    end
  end

  // Combinational read mux; loads always return a zero-extended word.
  always_comb begin
    rdData = '0;
    case (regSel)
      REG_STATUS: begin
        rdData[STAT_BUSY]                         = busy;
        rdData[STAT_FULL]                         = fifoFull;
        rdData[STAT_EMPTY]                        = fifoEmpty;
        rdData[STAT_COUNT_LO +: STAT_COUNT_W]     = STAT_COUNT_W'(fifoCount);
        rdData[STAT_OVF]                          = overflow_q;
      end
      REG_BAUDDIV: rdData[DIV_W-1:0] = baudDiv_q;
      REG_CTRL: begin
        rdData[CTRL_TXEN]  = txEn_q;
        rdData[CTRL_IRQEN] = irqEn_q;
      end
      default: rdData = '0;
    endcase
    data_out = rdStrobe ? rdData : '0;
  end

  // Transmit FSM next state. The divisor is captured into bitDiv at the
  // start of each frame so BAUDDIV writes during a frame only affect the
  // next one. tx_enable is only consulted in IDLE, so clearing it lets a
  // frame in progress run to its stop bit. Because leaving IDLE needs a
  // full cycle in IDLE, frames are always separated by one idle cycle.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitDiv_d  = bitDiv_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    popReq    = 1'b0;
    bitEnd    = (baudCnt_q == (bitDiv_q - 16'd1));

    if (state_q != ST_IDLE) begin
      baudCnt_d = bitEnd ? '0 : (baudCnt_q + 16'd1);
    end

    case (state_q)
      ST_IDLE: begin
        if (txEn_q && !fifoEmpty) begin
          popReq    = 1'b1;
          shift_d   = fifoHead;
          bitDiv_d  = effDiv(baudDiv_q);
          bitCnt_d  = '0;
          baudCnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bitEnd) begin
          bitCnt_d = '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bitEnd) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bitCnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bitEnd) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The line level is registered from the next state so tx changes on
    // the same edge as the FSM and never glitches.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase

    irq_d = irqEn_q && fifoEmpty && (state_q == ST_IDLE);
  end

  // Transmit engine state; reset aborts any frame and forces the line high
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      baudCnt_q <= '0;
      bitDiv_q  <= effDiv(DIV_RESET);
      bitCnt_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitDiv_q  <= bitDiv_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_perif_uart_tx.sv
// Directed bench for perif_uart_tx. Inputs change in the low clock phase,
// outputs are sampled at negedges, away from the active rising edge.
module tb_perif_uart_tx;

  localparam logic [31:0] A_TXDATA  = 32'h0000_0000;
  localparam logic [31:0] A_STATUS  = 32'h0000_0008;
  localparam logic [31:0] A_BAUDDIV = 32'h0000_0010;
  localparam logic [31:0] A_CTRL    = 32'h0000_0018;

  logic        clock = 1'b0;
  logic        reset;
  logic        cs;
  logic [31:0] address;
  logic        write_en;
  logic [1:0]  size;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        data_out_en;
  logic        tx;
  logic        tx_irq;

  int checks = 0;
  int errors = 0;

  perif_uart_tx #(
    .FIFO_DEPTH (4),
    .DIV_RESET  (16'd4),
    .DATA_W     (64)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cs          (cs),
    .address     (address),
    .write_en    (write_en),
    .size        (size),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_out_en (data_out_en),
    .tx          (tx),
    .tx_irq      (tx_irq)
  );

  always #5 clock = ~clock;

  // Expected tx samples of one frame, one sample per clock: start 0,
  // data LSB first, stop 1, each held for div clocks.
  function automatic logic [159:0] expFrame(input logic [7:0] b, input int div);
    logic [9:0]   bits;
    logic [159:0] r;
    bits = {1'b1, b, 1'b0};
    r = '0;
    for (int i = 0; i < 10 * div; i++) begin
      r[i] = bits[i / div];
    end
    return r;
  endfunction

  // Called in the low phase; the store commits on the next rising edge and
  // the task returns at the following negedge.
  task automatic busWrite(input logic [31:0] addr, input logic [63:0] d);
    cs       = 1'b1;
    write_en = 1'b1;
    address  = addr;
    data_in  = d;
    @(negedge clock);
    cs       = 1'b0;
    write_en = 1'b0;
  endtask

  // Combinational load, sampled 1 time unit after presenting the address
  task automatic busRead(input logic [31:0] addr, output logic [63:0] d, output logic en);
    cs       = 1'b1;
    write_en = 1'b0;
    address  = addr;
    #1;
    d  = data_out;
    en = data_out_en;
    #1;
    cs = 1'b0;
  endtask

  // Wait (bounded) for tx to fall, then record n negedge samples
  task automatic captureFrame(input int maxWait, input int n, output int waitCycles,
                              output logic [159:0] s);
    s = '0;
    waitCycles = 0;
    while (tx !== 1'b0 && waitCycles < maxWait) begin
      @(negedge clock);
      waitCycles++;
    end
    s[0] = tx;
    for (int i = 1; i < n; i++) begin
      @(negedge clock);
      s[i] = tx;
    end
  endtask

  task automatic test_reset();
    logic [63:0] d;
    logic        en;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
    checks++;
    if (tx_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", tx_irq); end
    checks++;
    if (data_out_en !== 1'b0 || data_out !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_dout: got en=%b d=%h expected en=0 d=0", data_out_en, data_out);
    end
    reset = 1'b0;
    @(negedge clock);
    busRead(A_STATUS, d, en);
    checks++;
    if (d !== 64'h4 || en !== 1'b1) begin errors++; $display("[TB] FAIL reset_status: got %h en=%b expected 4 en=1", d, en); end
    busRead(A_BAUDDIV, d, en);
    checks++;
    if (d !== 64'h4) begin errors++; $display("[TB] FAIL reset_baud: got %h expected 4", d); end
    busRead(A_CTRL, d, en);
    checks++;
    if (d !== 64'h1) begin errors++; $display("[TB] FAIL reset_ctrl: got %h expected 1", d); end
    busRead(A_TXDATA, d, en);
    checks++;
    if (d !== 64'h0) begin errors++; $display("[TB] FAIL txdata_read: got %h expected 0", d); end
    #1;
    checks++;
    if (data_out !== 64'h0 || data_out_en !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_dout: got en=%b d=%h expected en=0 d=0", data_out_en, data_out);
    end
    @(negedge clock);
  endtask

  task automatic test_single_frame();
    logic [63:0]  d;
    logic         en;
    int           w;
    logic [159:0] s;
    busWrite(A_TXDATA, 64'h55);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL tx_before_start: got %b expected 1", tx); end
    captureFrame(5, 40, w, s);
    checks++;
    if (w !== 1) begin errors++; $display("[TB] FAIL start_latency: got %0d expected 1", w); end
    checks++;
    if (s !== expFrame(8'h55, 4)) begin errors++; $display("[TB] FAIL frame_55: got %h expected %h", s, expFrame(8'h55, 4)); end
    busRead(A_STATUS, d, en);
    checks++;
    if (d !== 64'h5) begin errors++; $display("[TB] FAIL busy_last_cycle: got %h expected 5", d); end
    @(negedge clock);
    busRead(A_STATUS, d, en);
    checks++;
    if (d !== 64'h4) begin errors++; $display("[TB] FAIL idle_after_frame: got %h expected 4", d); end
    @(negedge clock);
  endtask

  task automatic test_overflow();
    logic [63:0] d;
    logic        en;
    busWrite(A_CTRL, 64'h0);
    for (int i = 0; i < 5; i++) begin
      busWrite(A_TXDATA, 64'h41 + 64'(i));
    end
    busRead(A_STATUS, d, en);
    checks++;
    if (d !== 64'h62) begin errors++; $display("[TB] FAIL overflow_status: got %h expected 62", d); end
    checks++;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL disabled_tx: got %b expected 1", tx); end
    busRead(A_CTRL, d, en);
    checks++;
    if (d !== 64'h0) begin errors++; $display("[TB] FAIL ctrl_cleared: got %h expected 0", d); end
    @(negedge clock);
  endtask

  task automatic test_overflow_clear();
    logic [63:0] d;
    logic        en;
    busWrite(A_STATUS | 32'h1000_0000, 64'hFFFF_FFFF_FFFF_FFBF);
    busRead(A_STATUS, d, en);
    checks++;
    if (d !== 64'h62) begin errors++; $display("[TB] FAIL status_write_noclear: got %h expected 62", d); end
    @(negedge clock);
    busWrite(A_STATUS, 64'h40);
    busRead(A_STATUS, d, en);
    checks++;
    if (d !== 64'h22) begin errors++; $display("[TB] FAIL overflow_clear: got %h expected 22", d); end
    @(negedge clock);
  endtask

  task automatic test_drain();
    logic [63:0]  d;
    logic         en;
    int           w;
    int           lowSeen;
    logic [159:0] s;
    busWrite(A_CTRL, 64'h1);
    for (int f = 0; f < 4; f++) begin
      captureFrame(5, 40, w, s);
      checks++;
      if (w !== ((f == 0) ? 1 : 2)) begin errors++; $display("[TB] FAIL drain_gap%0d: got %0d expected %0d", f, w, (f == 0) ? 1 : 2); end
      checks++;
      if (s !== expFrame(8'h41 + 8'(f), 4)) begin
        errors++; $display("[TB] FAIL drain_frame%0d: got %h expected %h", f, s, expFrame(8'h41 + 8'(f), 4));
      end
    end
    lowSeen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) lowSeen++;
    end
    checks++;
    if (lowSeen !== 0) begin errors++; $display("[TB] FAIL dropped_byte_sent: got %0d low cycles expected 0", lowSeen); end
    busRead(A_STATUS, d, en);
    checks++;
    if (d !== 64'h4) begin errors++; $display("[TB] FAIL drain_status: got %h expected 4", d); end
    @(negedge clock);
  endtask

  task automatic test_baud_change();
    logic [63:0]  d;
    logic         en;
    int           w;
    logic [159:0] s;
    busWrite(A_CTRL, 64'h0);
    busWrite(A_TXDATA, 64'hA5);
    busWrite(A_TXDATA, 64'h3C);
    busWrite(A_CTRL, 64'h1);
    fork
      captureFrame(5, 40, w, s);
      begin
        repeat (10) @(negedge clock);
        busWrite(A_BAUDDIV, 64'h8);
      end
    join
    checks++;
    if (w !== 1 || s !== expFrame(8'hA5, 4)) begin
      errors++; $display("[TB] FAIL baud_old_frame: got w=%0d %h expected w=1 %h", w, s, expFrame(8'hA5, 4));
    end
    captureFrame(5, 80, w, s);
    checks++;
    if (w !== 2 || s !== expFrame(8'h3C, 8)) begin
      errors++; $display("[TB] FAIL baud_new_frame: got w=%0d %h expected w=2 %h", w, s, expFrame(8'h3C, 8));
    end
    busRead(A_BAUDDIV, d, en);
    checks++;
    if (d !== 64'h8) begin errors++; $display("[TB] FAIL baud_read8: got %h expected 8", d); end
    @(negedge clock);
    busWrite(A_BAUDDIV, 64'h0);
    busRead(A_BAUDDIV, d, en);
    checks++;
    if (d !== 64'h0) begin errors++; $display("[TB] FAIL baud_read0: got %h expected 0", d); end
    @(negedge clock);
    busWrite(A_TXDATA, 64'h96);
    captureFrame(5, 10, w, s);
    checks++;
    if (w !== 1 || s !== expFrame(8'h96, 1)) begin
      errors++; $display("[TB] FAIL baud_zero_frame: got w=%0d %h expected w=1 %h", w, s, expFrame(8'h96, 1));
    end
    busRead(A_STATUS, d, en);
    checks++;
    if (d !== 64'h5) begin errors++; $display("[TB] FAIL baud_zero_busy: got %h expected 5", d); end
    @(negedge clock);
    busRead(A_STATUS, d, en);
    checks++;
    if (d !== 64'h4) begin errors++; $display("[TB] FAIL baud_zero_idle: got %h expected 4", d); end
    @(negedge clock);
    busWrite(A_BAUDDIV, 64'h4);
  endtask

  task automatic test_irq_and_reset();
    logic [63:0] d;
    logic        en;
    int          lowSeen;
    logic        expIrq;
    busWrite(A_CTRL, 64'h3);
    checks++;
    if (tx_irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_before_enable: got %b expected 0", tx_irq); end
    @(negedge clock);
    checks++;
    if (tx_irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_enabled_idle: got %b expected 1", tx_irq); end
    busWrite(A_TXDATA, 64'h5A);
    checks++;
    if (tx_irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_at_push: got %b expected 1", tx_irq); end
    for (int k = 1; k <= 42; k++) begin
      @(negedge clock);
      expIrq = (k >= 42);
      checks++;
      if (tx_irq !== expIrq) begin errors++; $display("[TB] FAIL irq_cycle%0d: got %b expected %b", k, tx_irq, expIrq); end
    end
    // Reset in the middle of the data bits of a 0x00 frame
    busWrite(A_TXDATA, 64'h00);
    busWrite(A_TXDATA, 64'h77);
    repeat (8) @(negedge clock);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset_data: got %b expected 0", tx); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1 || tx_irq !== 1'b0) begin
      errors++; $display("[TB] FAIL midframe_reset: got tx=%b irq=%b expected tx=1 irq=0", tx, tx_irq);
    end
    busRead(A_STATUS, d, en);
    checks++;
    if (d !== 64'h4) begin errors++; $display("[TB] FAIL reset_fifo_empty: got %h expected 4", d); end
    busRead(A_CTRL, d, en);
    checks++;
    if (d !== 64'h1) begin errors++; $display("[TB] FAIL reset_ctrl_again: got %h expected 1", d); end
    @(negedge clock);
    reset = 1'b0;
    lowSeen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) lowSeen++;
    end
    checks++;
    if (lowSeen !== 0) begin errors++; $display("[TB] FAIL lost_byte_sent: got %0d low cycles expected 0", lowSeen); end
  endtask

  initial begin
    reset    = 1'b1;
    cs       = 1'b0;
    write_en = 1'b0;
    address  = '0;
    size     = 2'b11;
    data_in  = '0;
    $display("[TB] starting perif_uart_tx bench");
    test_reset();
    test_single_frame();
    test_overflow();
    test_overflow_clear();
    test_drain();
    test_baud_change();
    test_irq_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
